// File: rtl/regfile_dump_if.sv
// Bus bundle for the register-file dump reader: control, register-file read port
// and the valid/ready output stream.
interface regfile_dump_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              start;
   logic [ADDR_W-1:0] first_addr;
   logic [ADDR_W-1:0] last_addr;
   logic              abort;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic              busy;
   logic              done;

   modport master (
      input  start, first_addr, last_addr, abort, rd_data, out_ready,
      output rd_addr, out_valid, out_data, out_addr, out_last, busy, done
   );

   modport slave (
      output start, first_addr, last_addr, abort, rd_data, out_ready,
      input  rd_addr, out_valid, out_data, out_addr, out_last, busy, done
   );
endinterface

// File: rtl/regfile_dump.sv
// Sequential register-file reader: sweeps first..last (wrapping) through one read
// port and streams each word out on a valid/ready handshake.
module regfile_dump #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic           clk,
   input  logic           rst,
   regfile_dump_if.master bus
);

   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rd_addr_q  <= '0;
         last_q     <= '0;
         out_data_q <= '0;
         out_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         last_q     <= last_d;
         out_data_q <= out_data_d;
         out_addr_q <= out_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      last_d     = last_q;
      out_data_d = out_data_q;
      out_addr_d = out_addr_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               last_d    = bus.last_addr;
               rd_addr_d = bus.first_addr;
               state_d   = READ;
            end
         end
         READ: begin
            out_data_d = bus.rd_data;
            out_addr_d = rd_addr_q;
            state_d    = SEND;
         end
         SEND: begin
            if (bus.out_ready) begin
               if (out_addr_q == last_q) begin
                  state_d = DONE;
               end else begin
                  // Address wraps naturally at 2^ADDR_W, so first > last sweeps through 0.
                  rd_addr_d = out_addr_q + ADDR_W'(1);
                  state_d   = READ;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort overrides every transition; a word handshaken this cycle still counts as taken.
      if (bus.abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end
   end

   // All status outputs decode the state register so reset clears them without a clock.
   assign bus.rd_addr   = rd_addr_q;
   assign bus.out_valid = (state_q == SEND);
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_last  = (state_q == SEND) && (out_addr_q == last_q);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural 32x32 register file model.
module tb_regfile_dump;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   logic [31:0] regs [32];

   regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   assign bus.rd_data = regs[bus.rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_busy"},  32'(bus.busy),      32'd0);
      check({tag, "_done"},  32'(bus.done),      32'd0);
   endtask

   // Waits (bounded) for out_valid, checks the word, then lets the handshake edge pass.
   task automatic expect_word(input string tag, input logic [4:0] a, input logic l);
      int n;
      n = 0;
      while (!bus.out_valid && n < 6) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_addr"},  32'(bus.out_addr),  32'(a));
      check({tag, "_data"},  bus.out_data,       regs[a]);
      check({tag, "_last"},  32'(bus.out_last),  32'(l));
      tick();
   endtask

   task automatic expect_done(input string tag);
      int n;
      n = 0;
      while (!bus.done && n < 4) begin
         tick();
         n++;
      end
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      tick();
      check({tag, "_done_end"}, 32'(bus.done), 32'd0);
      check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 32; i++) regs[i] = 32'hA5000000 | (32'(i) << 8) | 32'(i);
      regs[1] = 32'hBEEEEEEF;
      regs[2] = 32'h00000002;

      rst            = 1'b0;
      bus.start      = 1'b0;
      bus.first_addr = '0;
      bus.last_addr  = '0;
      bus.abort      = 1'b0;
      bus.out_ready  = 1'b0;
      #1;
      check_idle("reset");
      check("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
      check("reset_out_data", bus.out_data, 32'd0);
      check("reset_out_last", 32'(bus.out_last), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Two-word dump with cycle-exact timing.
      bus.first_addr = 5'd1;
      bus.last_addr  = 5'd2;
      bus.out_ready  = 1'b1;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      check("t1_busy", 32'(bus.busy), 32'd1);
      check("t1_read_valid", 32'(bus.out_valid), 32'd0);
      check("t1_rd_addr", 32'(bus.rd_addr), 32'd1);
      tick();
      check("t1_w0_valid", 32'(bus.out_valid), 32'd1);
      check("t1_w0_addr", 32'(bus.out_addr), 32'd1);
      check("t1_w0_data", bus.out_data, 32'hBEEEEEEF);
      check("t1_w0_last", 32'(bus.out_last), 32'd0);
      tick();
      check("t1_gap_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("t1_w1_valid", 32'(bus.out_valid), 32'd1);
      check("t1_w1_addr", 32'(bus.out_addr), 32'd2);
      check("t1_w1_data", bus.out_data, 32'h00000002);
      check("t1_w1_last", 32'(bus.out_last), 32'd1);
      tick();
      check("t1_done", 32'(bus.done), 32'd1);
      check("t1_done_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check_idle("t1_end");

      // Wrapping range 30..1.
      bus.first_addr = 5'd30;
      bus.last_addr  = 5'd1;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      expect_word("t2_a30", 5'd30, 1'b0);
      expect_word("t2_a31", 5'd31, 1'b0);
      expect_word("t2_a0",  5'd0,  1'b0);
      expect_word("t2_a1",  5'd1,  1'b1);
      expect_done("t2");

      // Single word with back-pressure.
      bus.first_addr = 5'd5;
      bus.last_addr  = 5'd5;
      bus.out_ready  = 1'b0;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int c = 0; c < 4; c++) begin
         check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
         check("t3_hold_addr", 32'(bus.out_addr), 32'd5);
         check("t3_hold_data", bus.out_data, regs[5]);
         check("t3_hold_last", 32'(bus.out_last), 32'd1);
         check("t3_hold_done", 32'(bus.done), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("t3_done", 32'(bus.done), 32'd1);
      tick();
      check_idle("t3_end");

      // Abort during the second SEND of 0..7, coincident with a handshake.
      bus.first_addr = 5'd0;
      bus.last_addr  = 5'd7;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      check("t4_s0_addr", 32'(bus.out_addr), 32'd0);
      tick();
      tick();
      check("t4_s1_valid", 32'(bus.out_valid), 32'd1);
      check("t4_s1_addr", 32'(bus.out_addr), 32'd1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check_idle("t4_abort");
      for (int c = 0; c < 3; c++) begin
         tick();
         check_idle("t4_after");
      end

      // Asynchronous reset during READ, then an immediate restart.
      bus.first_addr = 5'd3;
      bus.last_addr  = 5'd4;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      check("t5_in_read", 32'(bus.busy), 32'd1);
      #1 rst = 1'b0;
      #1;
      check_idle("t5_async");
      check("t5_rd_addr", 32'(bus.rd_addr), 32'd0);
      check("t5_out_addr", 32'(bus.out_addr), 32'd0);
      check("t5_out_data", bus.out_data, 32'd0);
      check("t5_out_last", 32'(bus.out_last), 32'd0);
      tick();
      rst            = 1'b1;
      bus.first_addr = 5'd6;
      bus.last_addr  = 5'd6;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      check("t5_restart_busy", 32'(bus.busy), 32'd1);
      expect_word("t5_a6", 5'd6, 1'b1);
      expect_done("t5");

      // start while busy is ignored.
      bus.first_addr = 5'd9;
      bus.last_addr  = 5'd10;
      bus.start      = 1'b1;
      tick();
      bus.first_addr = 5'd20;
      bus.last_addr  = 5'd21;
      tick();
      bus.start = 1'b0;
      expect_word("t6_a9",  5'd9,  1'b0);
      expect_word("t6_a10", 5'd10, 1'b1);
      expect_done("t6");
      tick();
      check_idle("t6_end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Sequential reader for the 32x32 register file. It sweeps a register address range through one read port and streams each word out on a valid/ready interface for debug and test readback.

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register word width.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width (32 registers).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a dump; sampled only in IDLE.
REQ-006 SHALL have port first_addr, input, ADDR_W bits: first register to read; sampled with start.
REQ-007 SHALL have port last_addr, input, ADDR_W bits: last register to read; sampled with start.
REQ-008 SHALL have port abort, input, 1 bit: cancel the dump in progress.
REQ-009 SHALL have port rd_addr, output, ADDR_W bits: drives the register file read address.
REQ-010 SHALL have port rd_data, input, DATA_W bits: combinational read data from the register file.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data/out_addr/out_last are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the word.
REQ-013 SHALL have port out_data, output, DATA_W bits: captured register value.
REQ-014 SHALL have port out_addr, output, ADDR_W bits: address of out_data.
REQ-015 SHALL have port out_last, output, 1 bit: high with the final word of the range.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse after the last word is accepted.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, READ, SEND, DONE.
REQ-019 In IDLE, start=1 SHALL latch first_addr and last_addr, load rd_addr=first_addr, and go to READ on the next edge.
REQ-020 In READ, the block SHALL capture rd_data into out_data and rd_addr into out_addr at the clock edge, then go to SEND.
REQ-021 In SEND, out_valid SHALL be 1, and out_data/out_addr/out_last SHALL hold stable until out_ready=1.
REQ-022 In SEND with out_ready=1 and out_addr != latched last, the block SHALL set rd_addr to out_addr+1 modulo 2^ADDR_W and go to READ.
REQ-023 In SEND with out_ready=1 and out_addr == latched last, the block SHALL go to DONE.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 out_last SHALL equal 1 exactly when out_valid=1 and out_addr == latched last.
REQ-026 Word count SHALL be ((last-first) mod 32)+1: first>last wraps 31->0, and first==last yields one word.
REQ-027 Minimum throughput SHALL be one word per 2 cycles; start-to-first-out_valid latency SHALL be 2 cycles.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with out_valid=0, and done SHALL NOT pulse.
REQ-030 abort=1 coincident with an out_ready handshake SHALL count that word as accepted, and the FSM SHALL still go to IDLE without a done pulse.
REQ-031 abort SHALL take priority over all other transitions; abort in IDLE SHALL have no effect.
REQ-032 The block SHALL NOT drive any register file write port; it is read-only.

Reset
REQ-033 rst=0 SHALL asynchronously force IDLE, rd_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0.
REQ-034 rst asserted mid-dump SHALL discard the latched range, and no word or done pulse SHALL appear after release.
REQ-035 After rst deassertion, the first start SHALL be honoured on the first rising edge.

Verification
REQ-036 Bench SHALL cover: regfile preloaded x1=32'hBEEEEEEF, x2=32'h00000002; start, first=1, last=2, out_ready=1 -> words (1,BEEEEEEF,last=0) then (2,00000002,last=1), then a done pulse, total 6 cycles from start.
REQ-037 Bench SHALL cover: first=30, last=1 -> out_addr sequence 30,31,0,1; out_last only on addr 1.
REQ-038 Bench SHALL cover: first=last=5, out_ready held 0 for 4 cycles -> out_valid high and out_data/out_addr stable all 4 cycles; done 1 cycle after ready rises.
REQ-039 Bench SHALL cover: abort during the second SEND of range 0..7 -> out_valid=0 the next cycle, busy=0, no done pulse.
REQ-040 Bench SHALL cover: rst=0 during READ -> all outputs zero immediately, without waiting for a clock edge; a new start after release dumps correctly.
REQ-041 Bench SHALL cover: start pulsed while busy -> ignored; the original range completes unchanged.
